// File: rtl/serdes_link_nbit.sv
// 4b/5b serial link: word encoder/serialiser with comma idle fill, plus deserialiser with comma lock FSM.
// Optional SERDES_LOOPBACK_EN: RX samples ser_out internally and ignores ser_in.
module serdes_link_nbit #(
  parameter int NIBBLES  = 2,
  parameter int LOCK_CNT = 2,
  parameter int LOSS_CNT = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [4*NIBBLES-1:0]   in_data,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic                   ser_out,
  input  logic                   ser_in,
  output logic [4*NIBBLES-1:0]   out_data,
  output logic                   out_valid,
  output logic                   out_err,
  output logic                   locked
);

  localparam int W  = 5 * NIBBLES;
  localparam int CW = $clog2(W);
  localparam int SW = $clog2(LOCK_CNT + 1);
  localparam int EW = $clog2(LOSS_CNT + 1);
  localparam logic [W-1:0] COMMA = {5'b11000, {(NIBBLES-1){5'b10001}}};

  typedef enum logic [1:0] {S_HUNT, S_SYNC, S_LOCKED} state_t;

  function automatic logic [4:0] enc5(input logic [3:0] n);
    case (n)
      4'h0: return 5'b11110;
      4'h1: return 5'b01001;
      4'h2: return 5'b10100;
      4'h3: return 5'b10101;
      4'h4: return 5'b01010;
      4'h5: return 5'b01011;
      4'h6: return 5'b01110;
      4'h7: return 5'b01111;
      4'h8: return 5'b10010;
      4'h9: return 5'b10011;
      4'hA: return 5'b10110;
      4'hB: return 5'b10111;
      4'hC: return 5'b11010;
      4'hD: return 5'b11011;
      4'hE: return 5'b11100;
      default: return 5'b11101;
    endcase
  endfunction

  // Returns {valid, nibble}; any code outside the table decodes as invalid.
  function automatic logic [4:0] sym_dec(input logic [4:0] s);
    case (s)
      5'b11110: return 5'h10;
      5'b01001: return 5'h11;
      5'b10100: return 5'h12;
      5'b10101: return 5'h13;
      5'b01010: return 5'h14;
      5'b01011: return 5'h15;
      5'b01110: return 5'h16;
      5'b01111: return 5'h17;
      5'b10010: return 5'h18;
      5'b10011: return 5'h19;
      5'b10110: return 5'h1A;
      5'b10111: return 5'h1B;
      5'b11010: return 5'h1C;
      5'b11011: return 5'h1D;
      5'b11100: return 5'h1E;
      5'b11101: return 5'h1F;
      default:  return 5'h00;
    endcase
  endfunction

  // ---------------- TX ----------------
  logic [W-1:0]  tx_sr;
  logic [W-1:0]  tx_enc;
  logic [CW-1:0] tx_bit;

  // NOTE: every variable gets a default at the top of always_comb so no path leaves it unassigned (no latch).
  always_comb begin
    tx_enc = '0;
    for (int j = 0; j < NIBBLES; j++) tx_enc[5*j +: 5] = enc5(in_data[4*j +: 4]);
  end

  assign in_ready = (tx_bit == CW'(W - 1));
  assign ser_out  = tx_sr[W-1];

  // NOTE: state registers use non-blocking assignments so all flops sample pre-edge values together.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_sr  <= COMMA;
      tx_bit <= '0;
    end else if (in_ready) begin
      tx_bit <= '0;
      tx_sr  <= in_valid ? tx_enc : COMMA;
    end else begin
      tx_bit <= tx_bit + 1'b1;
      tx_sr  <= {tx_sr[W-2:0], 1'b0};
    end
  end

  // ---------------- RX ----------------
  logic rx_bit;
`ifdef SERDES_LOOPBACK_EN
  assign rx_bit = ser_out;
`else
  assign rx_bit = ser_in;
`endif

  logic [W-1:0]          window;
  logic                  cmp;
  logic                  boundary;
  logic                  dec_ok;
  logic [4*NIBBLES-1:0]  dec_data;
  logic [4:0]            dec_sym [NIBBLES];
  state_t                state;
  logic [CW-1:0]         rx_cnt;
  logic [SW-1:0]         sync_cnt;
  logic [EW-1:0]         err_cnt;

  assign cmp      = (window == COMMA);
  assign boundary = (rx_cnt == '0);

  always_comb begin
    dec_ok   = 1'b1;
    dec_data = '0;
    for (int j = 0; j < NIBBLES; j++) begin
      dec_sym[j]         = sym_dec(window[5*j +: 5]);
      dec_ok             = dec_ok & dec_sym[j][4];
      dec_data[4*j +: 4] = dec_sym[j][3:0];
    end
  end

  // rx_cnt is loaded with 1 on detection: the detecting cycle itself counts as
  // position 0, so the next boundary lands exactly W cycles later.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      window    <= '0;
      state     <= S_HUNT;
      rx_cnt    <= '0;
      sync_cnt  <= '0;
      err_cnt   <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      out_err   <= 1'b0;
      locked    <= 1'b0;
    end else begin
      window    <= {window[W-2:0], rx_bit};
      out_valid <= 1'b0;
      out_err   <= 1'b0;
      rx_cnt    <= (rx_cnt == CW'(W - 1)) ? '0 : rx_cnt + 1'b1;
      case (state)
        S_HUNT: begin
          rx_cnt <= '0;
          if (cmp) begin
            rx_cnt   <= CW'(1);
            sync_cnt <= SW'(1);
            if (LOCK_CNT == 1) begin
              state  <= S_LOCKED;
              locked <= 1'b1;
            end else begin
              state <= S_SYNC;
            end
          end
        end
        S_SYNC: begin
          if (boundary) begin
            if (cmp) begin
              sync_cnt <= sync_cnt + 1'b1;
              if (sync_cnt + 1'b1 == SW'(LOCK_CNT)) begin
                state  <= S_LOCKED;
                locked <= 1'b1;
              end
            end else begin
              state    <= S_HUNT;
              rx_cnt   <= '0;
              sync_cnt <= '0;
            end
          end else if (cmp) begin
            rx_cnt   <= CW'(1);
            sync_cnt <= SW'(1);
          end
        end
        S_LOCKED: begin
          if (boundary) begin
            if (cmp) begin
              err_cnt <= '0;
            end else if (dec_ok) begin
              out_data  <= dec_data;
              out_valid <= 1'b1;
              err_cnt   <= '0;
            end else begin
              out_err <= 1'b1;
              if (err_cnt + 1'b1 == EW'(LOSS_CNT)) begin
                state    <= S_HUNT;
                locked   <= 1'b0;
                rx_cnt   <= '0;
                sync_cnt <= '0;
                err_cnt  <= '0;
              end else begin
                err_cnt <= err_cnt + 1'b1;
              end
            end
          end
        end
        default: begin
          state  <= S_HUNT;
          locked <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serdes_link_nbit.sv
// Self-checking bench for serdes_link_nbit: default instance looped back through a corruptible
// ser_in, plus a NIBBLES=4 / LOCK_CNT=3 instance with plain external loopback.
module tb_serdes_link_nbit;

  localparam int W    = 10;
  localparam int LCNT = 2;
  localparam int W4   = 20;
  localparam int L4   = 3;
  localparam logic [W-1:0]  COMMA  = 10'b1100010001;
  localparam logic [W4-1:0] COMMA4 = 20'b11000100011000110001;
  localparam logic [4:0] ENC [16] = '{5'b11110, 5'b01001, 5'b10100, 5'b10101,
                                      5'b01010, 5'b01011, 5'b01110, 5'b01111,
                                      5'b10010, 5'b10011, 5'b10110, 5'b10111,
                                      5'b11010, 5'b11011, 5'b11100, 5'b11101};

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [7:0]  in_data = '0;
  logic        in_valid = 1'b0;
  logic        in_ready, ser_out, ser_in;
  logic [7:0]  out_data;
  logic        out_valid, out_err, locked;
  logic        corrupt = 1'b0;

  logic [15:0] in_data4 = '0;
  logic        in_valid4 = 1'b0;
  logic        in_ready4, ser_out4, ser_in4;
  logic [15:0] out_data4;
  logic        out_valid4, out_err4, locked4;

  int total = 0;
  int bad   = 0;
  int cyc;

  always #5 clk = ~clk;

  assign ser_in  = corrupt ? 1'b0 : ser_out;
  assign ser_in4 = ser_out4;

  serdes_link_nbit dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .ser_out(ser_out), .ser_in(ser_in), .out_data(out_data), .out_valid(out_valid),
    .out_err(out_err), .locked(locked)
  );

  serdes_link_nbit #(.NIBBLES(4), .LOCK_CNT(L4), .LOSS_CNT(4)) dut4 (
    .clk(clk), .rst(rst), .in_data(in_data4), .in_valid(in_valid4), .in_ready(in_ready4),
    .ser_out(ser_out4), .ser_in(ser_in4), .out_data(out_data4), .out_valid(out_valid4),
    .out_err(out_err4), .locked(locked4)
  );

  // Cycle index: 0 is the cycle in which reset is released.
  always @(posedge clk or negedge rst)
    if (!rst) cyc <= 0;
    else      cyc <= cyc + 1;

  typedef struct { int c; logic [7:0] d; } ev_t;
  ev_t  ov_q[$];
  int   err_q[$];
  logic ser_hist [4096];

  always begin
    @(negedge clk);
    #2;
    if (rst) begin
      ser_hist[cyc % 4096] = ser_out;
      if (out_valid) ov_q.push_back('{cyc, out_data});
      if (out_err)   err_q.push_back(cyc);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic send_word(input logic [7:0] d, input bit corrupt_first, output int acc);
    int n = 0;
    in_data  = d;
    in_valid = 1'b1;
    while (!in_ready && n < W + 1) begin step(); n++; end
    if (!in_ready) begin
      total++; bad++;
      $display("FAIL send_timeout: in_ready got 0 want 1 within %0d cycles", W + 1);
      acc = -1000;
      in_valid = 1'b0;
      return;
    end
    acc = cyc;
    step();
    in_valid = 1'b0;
    if (corrupt_first) begin
      corrupt = 1'b1;
      repeat (5) step();
      corrupt = 1'b0;
    end
  endtask

  task automatic test_reset();
    step();
    rst = 1'b0; in_valid = 1'b0; in_valid4 = 1'b0; corrupt = 1'b0;
    #1;
    total++;
    if ({ser_out, in_ready, out_valid, out_err, locked} !== 5'b10000) begin
      bad++;
      $display("FAIL reset_ctrl: {ser_out,in_ready,out_valid,out_err,locked} got %b want 10000",
               {ser_out, in_ready, out_valid, out_err, locked});
    end
    total++;
    if (out_data !== 8'h00) begin bad++; $display("FAIL reset_data: got %h want 00", out_data); end
    total++;
    if ({ser_out4, in_ready4, out_valid4, out_err4, locked4} !== 5'b10000 || out_data4 !== 16'h0) begin
      bad++;
      $display("FAIL reset_wide: ctrl got %b data %h want 10000 0000",
               {ser_out4, in_ready4, out_valid4, out_err4, locked4}, out_data4);
    end
    step();
    ov_q.delete();
    err_q.delete();
    rst = 1'b1;
  endtask

  task automatic test_idle_lock(input string tag);
    for (int k = 0; k <= 40; k++) begin
      if (k > 0) step();
      total++;
      if (ser_out !== COMMA[W-1-(cyc % W)]) begin
        bad++; $display("FAIL %s_ser_out c%0d: got %b want %b", tag, cyc, ser_out, COMMA[W-1-(cyc % W)]);
      end
      total++;
      if (in_ready !== ((cyc % W) == W - 1)) begin
        bad++; $display("FAIL %s_in_ready c%0d: got %b want %b", tag, cyc, in_ready, (cyc % W) == W - 1);
      end
      total++;
      if (locked !== (cyc >= W * LCNT + 1)) begin
        bad++; $display("FAIL %s_locked c%0d: got %b want %b", tag, cyc, locked, cyc >= W * LCNT + 1);
      end
    end
    total++;
    if (ov_q.size() != 0 || err_q.size() != 0) begin
      bad++; $display("FAIL %s_no_output: valid pulses %0d err pulses %0d want 0 0", tag, ov_q.size(), err_q.size());
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] words [8];
    int acc [8];
    logic [W-1:0] exp_sym;
    bit ser_bad;
    words[0] = 8'hA5;
    words[1] = 8'h3C;
    for (int i = 2; i < 8; i++) words[i] = 8'($urandom);
    ov_q.delete();
    err_q.delete();
    for (int i = 0; i < 8; i++) begin
      if (i >= 2 && $urandom_range(0, 1) == 1) repeat (W) step();
      send_word(words[i], 1'b0, acc[i]);
    end
    repeat (2 * W + 4) step();
    total++;
    if (acc[1] - acc[0] !== W) begin bad++; $display("FAIL b2b_spacing: got %0d want %0d", acc[1] - acc[0], W); end
    total++;
    if (ov_q.size() != 8) begin
      bad++; $display("FAIL b2b_count: out_valid pulses got %0d want 8", ov_q.size());
    end else begin
      for (int i = 0; i < 8; i++) begin
        total++;
        if (ov_q[i].c !== acc[i] + W + 2) begin
          bad++; $display("FAIL b2b_latency[%0d]: cycle got %0d want %0d", i, ov_q[i].c, acc[i] + W + 2);
        end
        total++;
        if (ov_q[i].d !== words[i]) begin
          bad++; $display("FAIL b2b_data[%0d]: got %h want %h", i, ov_q[i].d, words[i]);
        end
      end
    end
    for (int i = 0; i < 8; i++) begin
      exp_sym = {ENC[words[i][7:4]], ENC[words[i][3:0]]};
      ser_bad = 1'b0;
      for (int b = 0; b < W; b++)
        if (ser_hist[(acc[i] + 1 + b) % 4096] !== exp_sym[W-1-b]) ser_bad = 1'b1;
      total++;
      if (ser_bad) begin bad++; $display("FAIL b2b_encode[%0d]: word %h serial stream differs from %b", i, words[i], exp_sym); end
    end
    total++;
    if (err_q.size() != 0) begin bad++; $display("FAIL b2b_err: out_err pulses got %0d want 0", err_q.size()); end
  endtask

  task automatic test_single_error();
    int a0, a1;
    bit lost = 1'b0;
    ov_q.delete();
    err_q.delete();
    send_word(8'h5A, 1'b1, a0);
    send_word(8'h81, 1'b0, a1);
    repeat (2 * W + 4) begin step(); if (!locked) lost = 1'b1; end
    total++;
    if (err_q.size() != 1) begin
      bad++; $display("FAIL err1_count: out_err pulses got %0d want 1", err_q.size());
    end else begin
      total++;
      if (err_q[0] !== a0 + W + 2) begin bad++; $display("FAIL err1_cycle: got %0d want %0d", err_q[0], a0 + W + 2); end
    end
    total++;
    if (ov_q.size() != 1) begin
      bad++; $display("FAIL err1_valid_count: out_valid pulses got %0d want 1", ov_q.size());
    end else begin
      total++;
      if (ov_q[0].d !== 8'h81 || ov_q[0].c !== a1 + W + 2) begin
        bad++; $display("FAIL err1_good_word: got %h@%0d want 81@%0d", ov_q[0].d, ov_q[0].c, a1 + W + 2);
      end
    end
    total++;
    if (lost) begin bad++; $display("FAIL err1_locked: locked got 0 want 1"); end
  endtask

  task automatic test_loss();
    int acc [4];
    int f;
    ov_q.delete();
    err_q.delete();
    for (int i = 0; i < 4; i++) send_word(8'($urandom), 1'b1, acc[i]);
    f = acc[3] + W + 2;
    while (cyc <= f + 2 * W) begin
      step();
      if (cyc == f - 1) begin
        total++; if (locked !== 1'b1) begin bad++; $display("FAIL loss_before: locked got %b want 1", locked); end
      end
      if (cyc == f) begin
        total++; if (locked !== 1'b0) begin bad++; $display("FAIL loss_drop: locked got %b want 0", locked); end
      end
      if (cyc == f + 2 * W - 1) begin
        total++; if (locked !== 1'b0) begin bad++; $display("FAIL loss_early: locked got %b want 0", locked); end
      end
      if (cyc == f + 2 * W) begin
        total++; if (locked !== 1'b1) begin bad++; $display("FAIL loss_relock: locked got %b want 1", locked); end
      end
    end
    total++;
    if (err_q.size() != 4) begin
      bad++; $display("FAIL loss_err_count: out_err pulses got %0d want 4", err_q.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        total++;
        if (err_q[i] !== acc[i] + W + 2) begin
          bad++; $display("FAIL loss_err_cycle[%0d]: got %0d want %0d", i, err_q[i], acc[i] + W + 2);
        end
      end
    end
    total++;
    if (ov_q.size() != 0) begin bad++; $display("FAIL loss_valid: out_valid pulses got %0d want 0", ov_q.size()); end
  endtask

  task automatic test_mid_reset();
    int a;
    send_word(8'h77, 1'b0, a);
    repeat (3) step();
    test_reset();
    test_idle_lock("relock");
  endtask

  task automatic test_wide();
    int n = 0;
    int acc;
    int got_c = -1;
    int cnt = 0;
    logic [15:0] got_d = '0;
    test_reset();
    for (int k = 0; k <= 62; k++) begin
      if (k > 0) step();
      if (cyc < 60) begin
        total++;
        if (ser_out4 !== COMMA4[W4-1-(cyc % W4)]) begin
          bad++; $display("FAIL wide_comma c%0d: got %b want %b", cyc, ser_out4, COMMA4[W4-1-(cyc % W4)]);
        end
      end
      total++;
      if (locked4 !== (cyc >= W4 * L4 + 1)) begin
        bad++; $display("FAIL wide_locked c%0d: got %b want %b", cyc, locked4, cyc >= W4 * L4 + 1);
      end
    end
    in_data4  = 16'hBEEF;
    in_valid4 = 1'b1;
    while (!in_ready4 && n < W4 + 1) begin step(); n++; end
    total++;
    if (!in_ready4) begin
      bad++; $display("FAIL wide_accept: in_ready got 0 want 1 within %0d cycles", W4 + 1);
      in_valid4 = 1'b0;
      return;
    end
    acc = cyc;
    step();
    in_valid4 = 1'b0;
    repeat (W4 + 6) begin
      step();
      if (out_valid4) begin cnt++; got_c = cyc; got_d = out_data4; end
    end
    total++;
    if (cnt != 1 || got_c !== acc + W4 + 2 || got_d !== 16'hBEEF) begin
      bad++; $display("FAIL wide_word: pulses %0d data %h@%0d want 1 beef@%0d", cnt, got_d, got_c, acc + W4 + 2);
    end
  endtask

  initial begin
    test_reset();
    test_idle_lock("idle");
    test_back_to_back();
    test_single_error();
    test_loss();
    test_mid_reset();
    test_wide();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
